// File: rtl/config_loader.sv
// config_loader: word-serial config loader with N_BANKS shadow contexts.
// Words are assembled MSB-first in a shift register, committed into a bank,
// or a bank is streamed back out. bank[active_ctx] drives config_bits.
module config_loader #(
    parameter  int LENGTH  = 64,
    parameter  int WORD_W  = 8,
    parameter  int N_BANKS = 2,
    localparam int WORDS   = LENGTH / WORD_W,
    localparam int BW      = (N_BANKS > 1) ? $clog2(N_BANKS) : 1,
    localparam int CW      = $clog2(WORDS + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WORD_W-1:0] in_data,
    input  logic              commit,
    input  logic [BW-1:0]     commit_bank,
    input  logic              readback,
    input  logic [BW-1:0]     rb_bank,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WORD_W-1:0] out_data,
    input  logic              abort,
    input  logic              ctx_switch,
    input  logic [BW-1:0]     ctx_sel,
    output logic [BW-1:0]     active_ctx,
    output logic [LENGTH-1:0] config_bits,
    output logic              full,
    output logic              commit_done,
    output logic              err
);

    typedef enum logic [1:0] {S_FILL, S_FULL, S_READ} state_t;

    localparam logic [BW:0]   NB     = (BW+1)'(N_BANKS);
    localparam logic [CW-1:0] LAST_C = CW'(WORDS - 1);

    state_t                          r_state;
    logic [CW-1:0]                   r_cnt;
    logic [LENGTH-1:0]               r_shreg;
    logic [N_BANKS-1:0][LENGTH-1:0]  r_banks;
    logic [BW-1:0]                   r_active;
    logic                            r_err;
    logic                            r_commit_done;

    logic w_cb_ok, w_rbb_ok, w_cs_ok;
    logic w_commit_ok, w_rb_ok, w_cmd_err, w_ctx_err;
    logic w_in_fire, w_out_fire, w_last;

    // Command decode: abort > commit > readback; a shadowed command is dropped silently.
    always_comb begin
        w_cb_ok     = {1'b0, commit_bank} < NB;
        w_rbb_ok    = {1'b0, rb_bank} < NB;
        w_cs_ok     = {1'b0, ctx_sel} < NB;
        w_commit_ok = commit && (r_state == S_FULL) && w_cb_ok;
        w_rb_ok     = !commit && readback && (r_state == S_FILL) &&
                      (r_cnt == '0) && w_rbb_ok;
        w_cmd_err   = !abort && ((commit && !w_commit_ok) ||
                                 (!commit && readback && !w_rb_ok));
        w_ctx_err   = ctx_switch && !w_cs_ok;
        w_in_fire   = in_valid && (r_state == S_FILL);
        w_out_fire  = out_ready && (r_state == S_READ);
        w_last      = (r_cnt == LAST_C);
    end

    // Loader state machine, bank storage, context select and status flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= S_FILL;
            r_cnt         <= '0;
            r_shreg       <= '0;
            r_banks       <= '0;
            r_active      <= '0;
            r_err         <= 1'b0;
            r_commit_done <= 1'b0;
        end else begin
            r_commit_done <= 1'b0;
            if (w_cmd_err || w_ctx_err)
                r_err <= 1'b1;
            // Context switch is independent of the loader state.
            if (ctx_switch && w_cs_ok)
                r_active <= ctx_sel;
            if (abort) begin
                // Shift register and banks are deliberately left intact.
                r_state <= S_FILL;
                r_cnt   <= '0;
            end else if (w_commit_ok) begin
                r_banks[commit_bank] <= r_shreg;
                r_cnt                <= '0;
                r_state              <= S_FILL;
                r_commit_done        <= 1'b1;
            end else if (w_rb_ok) begin
                r_shreg <= r_banks[rb_bank];
                r_cnt   <= '0;
                r_state <= S_READ;
            end else if (w_in_fire) begin
                r_shreg <= {r_shreg[LENGTH-WORD_W-1:0], in_data};
                r_cnt   <= r_cnt + CW'(1);
                if (w_last)
                    r_state <= S_FULL;
            end else if (w_out_fire) begin
                r_shreg <= {r_shreg[LENGTH-WORD_W-1:0], {WORD_W{1'b0}}};
                if (w_last) begin
                    r_cnt   <= '0;
                    r_state <= S_FILL;
                end else begin
                    r_cnt <= r_cnt + CW'(1);
                end
            end
        end
    end

    assign in_ready    = (r_state == S_FILL);
    assign out_valid   = (r_state == S_READ);
    assign full        = (r_state == S_FULL);
    assign out_data    = out_valid ? r_shreg[LENGTH-1 -: WORD_W] : '0;
    assign active_ctx  = r_active;
    assign config_bits = r_banks[r_active];
    assign commit_done = r_commit_done;
    assign err         = r_err;

endmodule

// File: tb/tb_config_loader.sv
// Table-driven bench for config_loader (LENGTH=16, WORD_W=4, N_BANKS=2).
module tb_config_loader;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready;
    logic [3:0]  in_data;
    logic        commit, commit_bank, readback, rb_bank;
    logic        out_valid, out_ready;
    logic [3:0]  out_data;
    logic        abort, ctx_switch, ctx_sel, active_ctx;
    logic [15:0] config_bits;
    logic        full, commit_done, err;

    int checks = 0;
    int errors = 0;

    config_loader #(.LENGTH(16), .WORD_W(4), .N_BANKS(2)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .commit(commit), .commit_bank(commit_bank),
        .readback(readback), .rb_bank(rb_bank),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .abort(abort), .ctx_switch(ctx_switch), .ctx_sel(ctx_sel),
        .active_ctx(active_ctx), .config_bits(config_bits),
        .full(full), .commit_done(commit_done), .err(err)
    );

    always #5 clk = ~clk;

    // One cycle of inputs plus the outputs expected just after that edge.
    typedef struct packed {
        logic        r, iv;
        logic [3:0]  d;
        logic        cm, cb, rb, rbb, orr, ab, cs, csel;
        logic        e_ir, e_ov;
        logic [3:0]  e_od;
        logic        e_fu, e_cd, e_er, e_ac;
        logic [15:0] e_cfg;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t v(input logic r, iv, input logic [3:0] d,
                               input logic cm, cb, rb, rbb, orr, ab, cs, csel,
                               input logic ir_, ov_, input logic [3:0] od_,
                               input logic fu_, cd_, er_, ac_, input logic [15:0] cfg_);
        vec_t t;
        t.r = r; t.iv = iv; t.d = d; t.cm = cm; t.cb = cb; t.rb = rb; t.rbb = rbb;
        t.orr = orr; t.ab = ab; t.cs = cs; t.csel = csel;
        t.e_ir = ir_; t.e_ov = ov_; t.e_od = od_; t.e_fu = fu_; t.e_cd = cd_;
        t.e_er = er_; t.e_ac = ac_; t.e_cfg = cfg_;
        return t;
    endfunction

    task automatic drive(input vec_t t);
        rst = t.r; in_valid = t.iv; in_data = t.d; commit = t.cm; commit_bank = t.cb;
        readback = t.rb; rb_bank = t.rbb; out_ready = t.orr; abort = t.ab;
        ctx_switch = t.cs; ctx_sel = t.csel;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Inputs only; expected fields unused.
    function automatic vec_t in_only(input logic iv, input logic [3:0] d, input logic cm,
                                     input logic rb, input logic ab, input logic cs,
                                     input logic csel);
        return v(0, iv, d, cm, 0, rb, 0, 0, ab, cs, csel, 0, 0, 0, 0, 0, 0, 0, 16'h0);
    endfunction

    initial begin
        logic [25:0] act, exp;
        //            r iv d    cm cb rb rbb or ab cs sl | ir ov od  fu cd er ac cfg
        tbl.push_back(v(0,1,4'hA, 0,0, 0,0, 0, 0, 0,0,   1, 0,4'h0, 0,0,0,0,16'h0000));
        tbl.push_back(v(0,1,4'hB, 0,0, 0,0, 0, 0, 0,0,   1, 0,4'h0, 0,0,0,0,16'h0000));
        tbl.push_back(v(0,1,4'hC, 0,0, 0,0, 0, 0, 0,0,   1, 0,4'h0, 0,0,0,0,16'h0000));
        tbl.push_back(v(0,1,4'hD, 0,0, 0,0, 0, 0, 0,0,   0, 0,4'h0, 1,0,0,0,16'h0000));
        tbl.push_back(v(0,1,4'hF, 0,0, 0,0, 0, 0, 0,0,   0, 0,4'h0, 1,0,0,0,16'h0000)); // ignored
        tbl.push_back(v(0,0,4'h0, 1,0, 0,0, 0, 0, 0,0,   1, 0,4'h0, 0,1,0,0,16'hABCD));
        tbl.push_back(v(0,0,4'h0, 0,0, 0,0, 0, 0, 0,0,   1, 0,4'h0, 0,0,0,0,16'hABCD));
        // readback bank 0 with out_ready 1,0,1,1,0,1
        tbl.push_back(v(0,0,4'h0, 0,0, 1,0, 0, 0, 0,0,   0, 1,4'hA, 0,0,0,0,16'hABCD));
        tbl.push_back(v(0,0,4'h0, 0,0, 0,0, 1, 0, 0,0,   0, 1,4'hB, 0,0,0,0,16'hABCD));
        tbl.push_back(v(0,0,4'h0, 0,0, 0,0, 0, 0, 0,0,   0, 1,4'hB, 0,0,0,0,16'hABCD));
        tbl.push_back(v(0,0,4'h0, 0,0, 0,0, 1, 0, 0,0,   0, 1,4'hC, 0,0,0,0,16'hABCD));
        tbl.push_back(v(0,0,4'h0, 0,0, 0,0, 1, 0, 0,0,   0, 1,4'hD, 0,0,0,0,16'hABCD));
        tbl.push_back(v(0,0,4'h0, 0,0, 0,0, 0, 0, 0,0,   0, 1,4'hD, 0,0,0,0,16'hABCD));
        tbl.push_back(v(0,0,4'h0, 0,0, 0,0, 1, 0, 0,0,   1, 0,4'h0, 0,0,0,0,16'hABCD));
        // 0x1234 into bank 1, then switch context
        tbl.push_back(v(0,1,4'h1, 0,0, 0,0, 0, 0, 0,0,   1, 0,4'h0, 0,0,0,0,16'hABCD));
        tbl.push_back(v(0,1,4'h2, 0,0, 0,0, 0, 0, 0,0,   1, 0,4'h0, 0,0,0,0,16'hABCD));
        tbl.push_back(v(0,1,4'h3, 0,0, 0,0, 0, 0, 0,0,   1, 0,4'h0, 0,0,0,0,16'hABCD));
        tbl.push_back(v(0,1,4'h4, 0,0, 0,0, 0, 0, 0,0,   0, 0,4'h0, 1,0,0,0,16'hABCD));
        tbl.push_back(v(0,0,4'h0, 1,1, 0,0, 0, 0, 0,0,   1, 0,4'h0, 0,1,0,0,16'hABCD));
        tbl.push_back(v(0,0,4'h0, 0,0, 0,0, 0, 0, 1,1,   1, 0,4'h0, 0,0,0,1,16'h1234));
        // 0x5A5A to bank 0 with same-edge switch back to context 0
        tbl.push_back(v(0,1,4'h5, 0,0, 0,0, 0, 0, 0,0,   1, 0,4'h0, 0,0,0,1,16'h1234));
        tbl.push_back(v(0,1,4'hA, 0,0, 0,0, 0, 0, 0,0,   1, 0,4'h0, 0,0,0,1,16'h1234));
        tbl.push_back(v(0,1,4'h5, 0,0, 0,0, 0, 0, 0,0,   1, 0,4'h0, 0,0,0,1,16'h1234));
        tbl.push_back(v(0,1,4'hA, 0,0, 0,0, 0, 0, 0,0,   0, 0,4'h0, 1,0,0,1,16'h1234));
        tbl.push_back(v(0,0,4'h0, 1,0, 0,0, 0, 0, 1,0,   1, 0,4'h0, 0,1,0,0,16'h5A5A));
        // premature commit: err, banks and count untouched
        tbl.push_back(v(0,1,4'h1, 0,0, 0,0, 0, 0, 0,0,   1, 0,4'h0, 0,0,0,0,16'h5A5A));
        tbl.push_back(v(0,1,4'h2, 0,0, 0,0, 0, 0, 0,0,   1, 0,4'h0, 0,0,0,0,16'h5A5A));
        tbl.push_back(v(0,0,4'h0, 1,0, 0,0, 0, 0, 0,0,   1, 0,4'h0, 0,0,1,0,16'h5A5A));
        tbl.push_back(v(0,1,4'h3, 0,0, 0,0, 0, 0, 0,0,   1, 0,4'h0, 0,0,1,0,16'h5A5A));
        tbl.push_back(v(0,1,4'h4, 0,0, 0,0, 0, 0, 0,0,   0, 0,4'h0, 1,0,1,0,16'h5A5A));
        tbl.push_back(v(0,0,4'h0, 0,0, 1,0, 0, 0, 0,0,   0, 0,4'h0, 1,0,1,0,16'h5A5A));
        tbl.push_back(v(0,0,4'h0, 0,0, 0,0, 0, 0, 1,1,   0, 0,4'h0, 1,0,1,1,16'h1234));
        // reset clears banks, err and context
        tbl.push_back(v(1,0,4'h0, 0,0, 0,0, 0, 0, 0,0,   1, 0,4'h0, 0,0,0,0,16'h0000));
        tbl.push_back(v(0,0,4'h0, 0,0, 0,0, 0, 0, 1,1,   1, 0,4'h0, 0,0,0,1,16'h0000));

        // reset state
        drive(v(1,0,0,0,0,0,0,0,0,0,0, 0,0,0,0,0,0,0,16'h0));
        drive(v(1,0,0,0,0,0,0,0,0,0,0, 0,0,0,0,0,0,0,16'h0));
        chk("reset", 32'({in_ready, out_valid, out_data, full, commit_done, err,
                          active_ctx, config_bits}),
            32'({1'b1, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000}));

        for (int i = 0; i < tbl.size(); i++) begin
            drive(tbl[i]);
            act = {in_ready, out_valid, out_data, full, commit_done, err, active_ctx, config_bits};
            exp = {tbl[i].e_ir, tbl[i].e_ov, tbl[i].e_od, tbl[i].e_fu, tbl[i].e_cd,
                   tbl[i].e_er, tbl[i].e_ac, tbl[i].e_cfg};
            checks++;
            if (act !== exp) begin
                errors++;
                $display("FAIL vec%0d: got ir=%b ov=%b od=%h fu=%b cd=%b er=%b ac=%b cfg=%h expected %h",
                         i, act[25], act[24], act[23:20], act[19], act[18], act[17], act[16],
                         act[15:0], exp);
            end
        end

        // abort mid-load, then a fresh 4-word load
        drive(in_only(1, 4'h7, 0, 0, 0, 1, 0));
        drive(in_only(1, 4'h7, 0, 0, 0, 0, 0));
        drive(in_only(1, 4'h7, 0, 0, 0, 0, 0));
        drive(in_only(0, 4'h0, 0, 0, 1, 0, 0));
        chk("abort_ready", 32'(in_ready), 32'(1));
        chk("abort_noerr", 32'(err), 32'(0));
        for (int i = 0; i < 3; i++) drive(in_only(1, 4'h5, 0, 0, 0, 0, 0));
        chk("abort_not_full", 32'(full), 32'(0));
        drive(in_only(1, 4'h5, 0, 0, 0, 0, 0));
        chk("abort_full", 32'(full), 32'(1));
        drive(in_only(0, 4'h0, 1, 0, 0, 0, 0));
        chk("abort_bank", 32'(config_bits), 32'(16'h5555));
        chk("abort_done", 32'(commit_done), 32'(1));
        chk("abort_err", 32'(err), 32'(0));

        // readback with a partial image is a protocol error and leaves FILL intact
        drive(in_only(1, 4'h1, 0, 0, 0, 0, 0));
        drive(in_only(0, 4'h0, 0, 1, 0, 0, 0));
        chk("rb_partial_err", 32'(err), 32'(1));
        chk("rb_partial_state", 32'({in_ready, out_valid}), 32'(2'b10));

        // abort during readback returns to FILL with banks intact
        drive(in_only(0, 4'h0, 0, 0, 1, 0, 0));
        drive(in_only(0, 4'h0, 0, 1, 0, 0, 0));
        chk("rb2_first", 32'({out_valid, out_data}), 32'({1'b1, 4'h5}));
        drive(in_only(0, 4'h0, 0, 0, 1, 0, 0));
        chk("rb2_abort", 32'({in_ready, out_valid, config_bits}), 32'({2'b10, 16'h5555}));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
